dark_min_frame_ctrl: RTL and testbench

- Frame-level sequencer for the 3x3 min filter in the dehaze dark-channel path.
- Per frame it:
  - clears the filter,
  - gates upstream pixels into it,
  - injects flush pixels after the last real pixel so the line-buffer latency drains,
  - counts filter outputs and tags exactly WIDTH*HEIGHT of them with coordinates and sof/eol/eof markers for the downstream transmission-map stage.
- Sits between the pixel source (valid/ready) and the filter (valid-only). It also drives the filter's active-low reset.

---
 rtl/dark_min_frame_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_dark_min_frame_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dark_min_frame_ctrl.sv
// rtl/dark_min_frame_ctrl.sv - frame sequencer and output tagger for the 3x3 dark-channel min filter
module dark_min_frame_ctrl #(
    parameter int WIDTH         = 160,
    parameter int HEIGHT        = 120,
    parameter int DATA_WIDTH    = 8,
    parameter int FLUSH_LEN     = 2*WIDTH+4,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DATA_WIDTH-1:0]     s_val,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      f_rst_n,
    output logic [DATA_WIDTH-1:0]     f_in_val,
    output logic                      f_in_valid,
    input  logic [DATA_WIDTH-1:0]     f_out_val,
    input  logic                      f_out_valid,
    output logic [DATA_WIDTH-1:0]     m_val,
    output logic                      m_valid,
    output logic [$clog2(WIDTH)-1:0]  m_x,
    output logic [$clog2(HEIGHT)-1:0] m_y,
    output logic                      m_sof,
    output logic                      m_eol,
    output logic                      m_eof,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      short_frame
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int FW   = $clog2(FLUSH_LEN + 1);
    localparam int TW   = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_LAST_IN  = CW'(NPIX - 1);
    localparam logic [CW-1:0] CNT_FULL     = CW'(NPIX);
    localparam logic [XW-1:0] X_LAST       = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST   = FW'(FLUSH_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          clear_cnt;
    logic [FW-1:0] flush_cnt;
    logic [TW-1:0] idle_cnt;
    logic          accept;
    logic          tag_active;
    logic          tag_en;

    // abort withdraws s_ready in the same cycle so no pixel is taken into a cancelled frame
    assign s_ready    = (state == S_STREAM) && !abort;
    assign accept     = s_ready && s_valid;
    assign busy       = (state != S_IDLE);
    assign tag_active = ((state == S_STREAM) || (state == S_FLUSH) || (state == S_DRAIN)) && !abort;
    assign tag_en     = tag_active && f_out_valid && (out_cnt < CNT_FULL);

    // frame sequencer, filter feed and output tagging share the counters, so they live together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            clear_cnt   <= 1'b0;
            flush_cnt   <= '0;
            idle_cnt    <= '0;
            f_rst_n     <= 1'b0;
            f_in_val    <= '0;
            f_in_valid  <= 1'b0;
            m_val       <= '0;
            m_valid     <= 1'b0;
            m_x         <= '0;
            m_y         <= '0;
            m_sof       <= 1'b0;
            m_eol       <= 1'b0;
            m_eof       <= 1'b0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            f_in_valid <= 1'b0;
            f_in_val   <= '0;
            frame_done <= 1'b0;
            m_valid    <= 1'b0;
            m_val      <= '0;
            m_x        <= '0;
            m_y        <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;

            // output path runs independently of the input path; extra filter outputs are dropped
            if (tag_en) begin
                m_valid <= 1'b1;
                m_val   <= f_out_val;
                m_x     <= x_cnt;
                m_y     <= y_cnt;
                m_sof   <= (x_cnt == '0) && (y_cnt == '0);
                m_eol   <= (x_cnt == X_LAST);
                m_eof   <= (x_cnt == X_LAST) && (y_cnt == Y_LAST);
                out_cnt <= out_cnt + 1'b1;
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end

            if (abort && (state != S_IDLE)) begin
                state     <= S_CLEAR;
                f_rst_n   <= 1'b0;
                clear_cnt <= 1'b0;
                in_cnt    <= '0;
                out_cnt   <= '0;
                x_cnt     <= '0;
                y_cnt     <= '0;
                flush_cnt <= '0;
                idle_cnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        f_rst_n <= 1'b1;
                        if (start) begin
                            state       <= S_CLEAR;
                            f_rst_n     <= 1'b0;
                            short_frame <= 1'b0;
                            clear_cnt   <= 1'b0;
                            in_cnt      <= '0;
                            out_cnt     <= '0;
                            x_cnt       <= '0;
                            y_cnt       <= '0;
                            flush_cnt   <= '0;
                            idle_cnt    <= '0;
                        end
                    end
                    S_CLEAR: begin
                        if (clear_cnt) begin
                            state   <= S_STREAM;
                            f_rst_n <= 1'b1;
                        end else begin
                            clear_cnt <= 1'b1;
                        end
                    end
                    S_STREAM: begin
                        if (accept) begin
                            f_in_valid <= 1'b1;
                            f_in_val   <= s_val;
                            in_cnt     <= in_cnt + 1'b1;
                            if (in_cnt == CNT_LAST_IN) begin
                                state     <= S_FLUSH;
                                flush_cnt <= '0;
                            end
                        end
                    end
                    S_FLUSH: begin
                        // all-ones never lowers a min, so flushing only pushes real results out
                        f_in_valid <= 1'b1;
                        f_in_val   <= '1;
                        if (flush_cnt == FLUSH_LAST) begin
                            state    <= S_DRAIN;
                            idle_cnt <= '0;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (out_cnt == CNT_FULL) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else if (f_out_valid) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == TIMEOUT_LAST) begin
                            state       <= S_DONE;
                            frame_done  <= 1'b1;
                            short_frame <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dark_min_frame_ctrl.sv
// tb/tb_dark_min_frame_ctrl.sv - directed self-checking bench for dark_min_frame_ctrl
module tb_dark_min_frame_ctrl;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int DW  = 8;
    localparam int FL  = 12;
    localparam int DT  = 15;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] s_val = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          f_rst_n;
    logic [DW-1:0] f_in_val;
    logic          f_in_valid;
    logic [DW-1:0] f_out_val = '0;
    logic          f_out_valid = 1'b0;
    logic [DW-1:0] m_val;
    logic          m_valid;
    logic [1:0]    m_x;
    logic [1:0]    m_y;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          busy;
    logic          frame_done;
    logic          short_frame;

    int checks = 0;
    int errors = 0;

    // monitor state
    int m_rec [32];
    int mcnt, fin_cnt, vcnt, frst_low, fd_cnt, cyc, fin_last, fd_at;
    int fin_val [64];
    bit vlog [128];
    bit eof_seen;

    // filter model state
    logic [DW-1:0] hist [64];
    int mdl_cnt, mdl_emit;
    int emit_limit = 99;

    dark_min_frame_ctrl #(
        .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .FLUSH_LEN(FL), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_val(s_val), .s_valid(s_valid), .s_ready(s_ready),
        .f_rst_n(f_rst_n), .f_in_val(f_in_val), .f_in_valid(f_in_valid),
        .f_out_val(f_out_val), .f_out_valid(f_out_valid),
        .m_val(m_val), .m_valid(m_valid), .m_x(m_x), .m_y(m_y),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .frame_done(frame_done), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    // behavioural filter: fixed pipeline latency, output count capped by emit_limit
    always @(negedge clk) begin
        f_out_valid = 1'b0;
        f_out_val   = '0;
        if (!f_rst_n) begin
            mdl_cnt  = 0;
            mdl_emit = 0;
        end else if (f_in_valid) begin
            if (mdl_cnt < 64) hist[mdl_cnt] = f_in_val;
            if (mdl_cnt >= LAT && mdl_emit < emit_limit) begin
                f_out_valid = 1'b1;
                f_out_val   = hist[mdl_cnt-LAT];
                mdl_emit++;
            end
            mdl_cnt++;
        end
    end

    // monitor
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (!f_rst_n) frst_low++;
            if (vcnt < 128) begin vlog[vcnt] = f_in_valid; vcnt++; end
            if (f_in_valid) begin
                if (fin_cnt < 64) fin_val[fin_cnt] = int'(f_in_val);
                fin_cnt++;
                fin_last = cyc;
            end
            if (m_valid) begin
                if (mcnt < 32)
                    m_rec[mcnt] = int'(m_val)*4096 + int'(m_x)*256 + int'(m_y)*16
                                + int'(m_sof)*4 + int'(m_eol)*2 + int'(m_eof);
                mcnt++;
                if (m_eof) eof_seen = 1'b1;
            end
            if (frame_done) begin fd_cnt++; fd_at = cyc; end
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_rec(input int i);
        return (10+i)*4096 + (i%W)*256 + (i/W)*16
             + ((i == 0) ? 4 : 0) + ((i%W == W-1) ? 2 : 0) + ((i == W*H-1) ? 1 : 0);
    endfunction

    task automatic clear_mon();
        #2;
        mcnt = 0; fin_cnt = 0; vcnt = 0; frst_low = 0; fd_cnt = 0;
        fin_last = 0; fd_at = 0; eof_seen = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_f_rst_n"}, f_rst_n, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (s_ready) ok = 1'b1;
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic feed(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_val   = DW'(10 + i);
            @(negedge clk);
            if (toggle) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (fd_cnt > 0) ok = 1'b1;
        end
        if (!ok) check("done_timeout", 0, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic run_frame(input bit toggle, input int limit);
        emit_limit = limit;
        @(negedge clk);
        clear_mon();
        pulse_start();
        wait_ready();
        feed(W*H, toggle);
        wait_done();
    endtask

    initial begin
        int first;
        #200000;
        $display("FAIL watchdog got 0 exp 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        // reset state
        do_reset("rst0");
        check("rst0_short", short_frame, 0);
        check("rst0_done", frame_done, 0);

        // 1: reset mid-STREAM after 5 pixels, then a full frame
        clear_mon();
        pulse_start();
        wait_ready();
        feed(5, 1'b0);
        do_reset("rst_mid");
        run_frame(1'b0, 99);
        check("s1_mcnt", mcnt, 12);
        check("s1_done", fd_cnt, 1);

        // 2: contiguous frame, full detail
        run_frame(1'b0, 99);
        check("s2_frst_low", frst_low, 2);
        check("s2_fin_cnt", fin_cnt, 24);
        for (int i = 0; i < 24; i++)
            check($sformatf("s2_fin%0d", i), fin_val[i], (i < 12) ? 10 + i : 255);
        check("s2_mcnt", mcnt, 12);
        for (int i = 0; i < 12; i++)
            check($sformatf("s2_m%0d", i), m_rec[i], exp_rec(i));
        check("s2_done", fd_cnt, 1);
        check("s2_short", short_frame, 0);

        // 3: upstream toggling 1/0
        run_frame(1'b1, 99);
        first = -1;
        for (int i = 0; i < vcnt && first < 0; i++)
            if (vlog[i]) first = i;
        check("s3_first_found", (first >= 0) ? 1 : 0, 1);
        if (first >= 0) begin
            for (int k = 0; k < 36; k++)
                check($sformatf("s3_vlog%0d", k), vlog[first+k],
                      (k < 23) ? ((k % 2 == 0) ? 1 : 0) : ((k < 35) ? 1 : 0));
        end
        check("s3_fin_cnt", fin_cnt, 24);
        check("s3_mcnt", mcnt, 12);
        for (int i = 0; i < 12; i++)
            check($sformatf("s3_m%0d", i), m_rec[i], exp_rec(i));
        check("s3_done", fd_cnt, 1);

        // 4: filter emits only 9 outputs -> drain timeout
        run_frame(1'b0, 9);
        check("s4_short", short_frame, 1);
        check("s4_done", fd_cnt, 1);
        check("s4_mcnt", mcnt, 9);
        check("s4_last_y", (mcnt > 0) ? ((m_rec[mcnt-1] >> 4) & 15) : 99, 2);
        check("s4_eof_seen", eof_seen, 0);
        check("s4_timeout_len", fd_at - fin_last, 15);

        // 5: filter emits 14 outputs -> exactly 12 tagged; start clears short_frame
        emit_limit = 14;
        @(negedge clk);
        clear_mon();
        pulse_start();
        #1;
        check("s5_short_cleared", short_frame, 0);
        wait_ready();
        feed(W*H, 1'b0);
        wait_done();
        check("s5_mcnt", mcnt, 12);
        check("s5_last", m_rec[11], exp_rec(11));
        check("s5_done", fd_cnt, 1);
        check("s5_short", short_frame, 0);

        // 6: abort during FLUSH, then abort in STREAM
        emit_limit = 99;
        @(negedge clk);
        clear_mon();
        pulse_start();
        wait_ready();
        feed(W*H, 1'b0);
        repeat (3) @(negedge clk);
        clear_mon();
        check("s6_busy_flush", busy, 1);
        abort = 1'b1;
        #1;
        check("s6_sready_flush", s_ready, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("s6_clear_frst", f_rst_n, 0);
        wait_ready();
        check("s6_frst_low", frst_low, 2);
        check("s6_sready", s_ready, 1);
        abort = 1'b1;
        #1;
        check("s6_sready_abort", s_ready, 0);
        @(negedge clk);
        abort = 1'b0;
        wait_ready();
        check("s6_busy", busy, 1);
        repeat (5) @(negedge clk);
        check("s6_no_done", fd_cnt, 0);

        // start together with abort in IDLE: start wins
        do_reset("rst6");
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("sa_busy", busy, 1);
        check("sa_frst", f_rst_n, 0);
        wait_ready();
        check("sa_frst_low", frst_low, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
